// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG decoder constants, types and zigzag scan table
package jpeg_pkg;

    localparam int COEFF_W = 12;
    localparam int BLOCK_N = 64;
    localparam int BLOCK_D = 8;
    localparam int COL_W   = BLOCK_D * COEFF_W;

    // Per-bank occupancy as seen by both the write and read sides
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Column readout sequencer
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_EMIT = 1'b1
    } rd_state_t;

    // Zigzag scan index -> natural index (row*8 + col)
    localparam logic [5:0] ZIGZAG [BLOCK_N] = '{
         6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zigzag_bank.sv
// rtl/zigzag_bank.sv - 64x12 coefficient bank with write port, column read and clear
module zigzag_bank
    import jpeg_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               wr_en,
    input  logic [5:0]         wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               clr,
    input  logic [2:0]         rd_col,
    output logic [COL_W-1:0]   col_data
);

    logic [COEFF_W-1:0] mem [BLOCK_N];

    // Storage: clear wins so a freed bank always restarts from all-zero
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < BLOCK_N; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < BLOCK_N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Column k row i lives at natural address {i, k}
    for (genvar g = 0; g < BLOCK_D; g++) begin : g_col
        assign col_data[g*COEFF_W +: COEFF_W] = mem[{3'(g), rd_col}];
    end

endmodule

// File: rtl/inverse_zigzag.sv
// rtl/inverse_zigzag.sv - ping-pong inverse zigzag reorder emitting 8 block columns
module inverse_zigzag
    import jpeg_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [COEFF_W-1:0] coeff_in,
    input  logic               coeff_valid_in,
    input  logic               eob_in,
    output logic               coeff_ready_out,
    output logic [COL_W-1:0]   column_out,
    output logic               valid_out
);

    bank_state_t        bank_st     [2];
    bank_state_t        bank_st_nxt [2];
    logic               wr_bank;
    logic               wr_bank_nxt;
    logic [5:0]         wr_idx;
    rd_state_t          rd_st;
    logic               rd_bank;
    logic [2:0]         rd_col;
    logic               xfer;
    logic               blk_done;
    logic               bank_free;
    logic [COL_W-1:0]   bank_col [2];
    logic [COL_W-1:0]   rd_data;

    assign xfer      = coeff_valid_in & coeff_ready_out;
    assign blk_done  = xfer & (eob_in | (wr_idx == 6'd63));
    assign bank_free = (rd_st == RD_EMIT) & (rd_col == 3'd7);
    assign rd_data   = rd_bank ? bank_col[1] : bank_col[0];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        zigzag_bank u_bank (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .wr_en    (xfer & (wr_bank == 1'(g))),
            .wr_addr  (ZIGZAG[wr_idx]),
            .wr_data  (coeff_in),
            .clr      (bank_free & (rd_bank == 1'(g))),
            .rd_col   (rd_col),
            .col_data (bank_col[g])
        );
    end

    // Next bank occupancy: free and fill touch different banks, so both apply
    always_comb begin
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        wr_bank_nxt    = wr_bank;
        if (bank_free) begin
            bank_st_nxt[rd_bank] = BANK_EMPTY;
        end
        if (xfer) begin
            bank_st_nxt[wr_bank] = blk_done ? BANK_FULL : BANK_FILLING;
        end
        if (blk_done) begin
            wr_bank_nxt = ~wr_bank;
        end
    end

    // Write side: zigzag index, bank flags, and ready registered from next state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bank_st[0]      <= BANK_EMPTY;
            bank_st[1]      <= BANK_EMPTY;
            wr_bank         <= 1'b0;
            wr_idx          <= '0;
            coeff_ready_out <= 1'b0;
        end else begin
            bank_st[0]      <= bank_st_nxt[0];
            bank_st[1]      <= bank_st_nxt[1];
            wr_bank         <= wr_bank_nxt;
            if (xfer) begin
                wr_idx <= blk_done ? 6'd0 : wr_idx + 6'd1;
            end
            coeff_ready_out <= (bank_st_nxt[wr_bank_nxt] != BANK_FULL);
        end
    end

    // Read side: wait for the oldest full bank, emit its 8 columns, free it
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_st      <= RD_IDLE;
            rd_bank    <= 1'b0;
            rd_col     <= '0;
            valid_out  <= 1'b0;
            column_out <= '0;
        end else begin
            case (rd_st)
                RD_IDLE: begin
                    valid_out  <= 1'b0;
                    column_out <= '0;
                    rd_col     <= '0;
                    if (bank_st[rd_bank] == BANK_FULL) begin
                        rd_st <= RD_EMIT;
                    end
                end
                RD_EMIT: begin
                    valid_out  <= 1'b1;
                    column_out <= rd_data;
                    rd_col     <= rd_col + 3'd1;
                    if (rd_col == 3'd7) begin
                        rd_bank <= ~rd_bank;
                        if (bank_st[~rd_bank] != BANK_FULL) begin
                            rd_st <= RD_IDLE;
                        end
                    end
                end
                default: begin
                    rd_st      <= RD_IDLE;
                    valid_out  <= 1'b0;
                    column_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_zigzag.sv
// tb/tb_inverse_zigzag.sv - scoreboard bench for the inverse zigzag reorder
module tb_inverse_zigzag;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [11:0] coeff_in;
    logic        coeff_valid_in;
    logic        eob_in;
    logic        coeff_ready_out;
    logic [95:0] column_out;
    logic        valid_out;

    int          checks = 0;
    int          errors = 0;
    int          zz [64];
    logic [11:0] blk [64];
    logic [95:0] sb_q [$];
    logic [95:0] col_log [1024];
    int          col_seen = 0;
    int          run = 0;
    int          max_run = 0;
    int          stall_cnt = 0;
    int          base;
    int          t;

    inverse_zigzag dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .coeff_in        (coeff_in),
        .coeff_valid_in  (coeff_valid_in),
        .eob_in          (eob_in),
        .coeff_ready_out (coeff_ready_out),
        .column_out      (column_out),
        .valid_out       (valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: pop expected columns, require zero output when idle
    always @(negedge clk_in) begin
        if (coeff_valid_in && !coeff_ready_out && !rst_in) stall_cnt++;
        if (rst_in) begin
            run = 0;
        end else if (valid_out) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed %h expected no column", column_out);
            end else begin
                check("column", column_out, sb_q.pop_front());
            end
            if (col_seen < 1024) col_log[col_seen] = column_out;
            col_seen++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
            check("idle_zero", column_out, 96'd0);
        end
    end

    task automatic send_coeff(input logic [11:0] val, input logic eob);
        int w;
        coeff_in       = val;
        eob_in         = eob;
        coeff_valid_in = 1'b1;
        w = 0;
        while (!coeff_ready_out && w < 2000) begin
            @(posedge clk_in);
            #1;
            w++;
        end
        if (w >= 2000) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout: observed ready=0 expected ready=1");
        end
        @(posedge clk_in);
        #1;
        coeff_valid_in = 1'b0;
        eob_in         = 1'b0;
    endtask

    // Model a block from blk[0..n-1]; push its columns, then drive it
    task automatic send_block(input int n);
        logic [11:0] nat [64];
        logic [95:0] col;
        for (int i = 0; i < 64; i++) nat[i] = 12'd0;
        for (int i = 0; i < n; i++) nat[zz[i]] = blk[i];
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 8; r++) col[r*12 +: 12] = nat[r*8 + k];
            sb_q.push_back(col);
        end
        for (int i = 0; i < n; i++) send_coeff(blk[i], (i == n - 1) && (n < 64));
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 2000) begin
            @(negedge clk_in);
            w++;
        end
        repeat (3) @(negedge clk_in);
        check("drain_empty", 96'(sb_q.size()), 96'd0);
    endtask

    task automatic rand_block();
        for (int i = 0; i < 64; i++) blk[i] = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        // Zigzag walk derived from anti-diagonal traversal
        t = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[t] = r * 8 + (s - r);
                    t++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[t] = r * 8 + (s - r);
                    t++;
                end
            end
        end

        rst_in = 1'b1;
        coeff_in = '0;
        coeff_valid_in = 1'b0;
        eob_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_valid", 96'(valid_out), 96'd0);
        check("rst_column", column_out, 96'd0);
        check("rst_ready", 96'(coeff_ready_out), 96'd0);
        rst_in = 1'b0;
        #1;
        check("ready_before_edge", 96'(coeff_ready_out), 96'd0);
        @(negedge clk_in);
        check("ready_after_rst", 96'(coeff_ready_out), 96'd1);

        // Ascending 1..64
        for (int i = 0; i < 64; i++) blk[i] = 12'(i + 1);
        base = col_seen;
        send_block(64);
        wait_drain();
        check("asc_col0", col_log[base],
              {12'd36, 12'd22, 12'd21, 12'd11, 12'd10, 12'd4, 12'd3, 12'd1});
        check("asc_col7", col_log[base + 7],
              {12'd64, 12'd62, 12'd61, 12'd55, 12'd54, 12'd44, 12'd43, 12'd29});
        check("asc_count", 96'(col_seen - base), 96'd8);

        // DC-only with early end of block, then a full block for residue
        blk[0] = 12'd100;
        send_block(1);
        rand_block();
        send_block(64);
        wait_drain();

        // Extreme negatives at first and last scan positions
        for (int i = 0; i < 64; i++) blk[i] = 12'd0;
        blk[0]  = 12'h800;
        blk[63] = 12'hFFF;
        base = col_seen;
        send_block(64);
        wait_drain();
        check("neg_col0", 96'(col_log[base][11:0]), 96'h800);
        check("neg_col7", 96'(col_log[base + 7][95:84]), 96'hFFF);

        // Three full blocks back to back: no stalls, 24 columns
        stall_cnt = 0;
        base = col_seen;
        for (int b = 0; b < 3; b++) begin
            rand_block();
            send_block(64);
        end
        wait_drain();
        check("b2b_full_stall", 96'(stall_cnt), 96'd0);
        check("b2b_full_count", 96'(col_seen - base), 96'd24);

        // Three DC-only blocks back to back: both banks full, gapless readout
        stall_cnt = 0;
        max_run = 0;
        base = col_seen;
        for (int b = 0; b < 3; b++) begin
            blk[0] = 12'(b + 5);
            send_block(1);
        end
        wait_drain();
        check("b2b_dc_run", 96'(max_run), 96'd24);
        check("b2b_dc_stalled", 96'(stall_cnt > 0), 96'd1);

        // Reset on the 4th emitted column
        rand_block();
        base = col_seen;
        send_block(64);
        t = 0;
        while (col_seen < base + 4 && t < 2000) begin
            @(negedge clk_in);
            t++;
        end
        check("mid_emit_reached", 96'(col_seen - base), 96'd4);
        #1;
        rst_in = 1'b1;
        #1;
        check("mid_rst_valid", 96'(valid_out), 96'd0);
        check("mid_rst_column", column_out, 96'd0);
        check("mid_rst_ready", 96'(coeff_ready_out), 96'd0);
        sb_q.delete();
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("ready_after_mid_rst", 96'(coeff_ready_out), 96'd1);

        // Partial fill discarded by reset
        for (int i = 0; i < 10; i++) send_coeff(12'(i + 200), 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rand_block();
        base = col_seen;
        send_block(64);
        wait_drain();
        check("post_rst_count", 96'(col_seen - base), 96'd8);

        repeat (20) @(negedge clk_in);
        check("final_queue", 96'(sb_q.size()), 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
